iob_uart_rx_fifo: RTL and testbench
===================================

Name: iob_uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART core.
- Drains the core's single-byte receive holding register into a DEPTH-entry FIFO by pulsing the core's read-enable, and presents buffered bytes to the CPU register interface as first-word-fall-through.
- Provides fill level, a programmable-threshold interrupt, and a sticky stall/overflow flag, so software does not have to poll per byte.

Parameters:
- DATA_W, 8: byte width; must match the core receive data width.
- ADDR_W, 4: log2 of FIFO depth (DEPTH = 2**ADDR_W = 16).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high, single clock domain.
- rst_soft_i  in  1  software reset; same effect as rst_i, synchronous.
- en_i  in  1  block enable; when low, no push, pop or flag update, and all state holds.
- core_rx_ready_i  in  1  core holds a received byte.
- core_rx_data_i  in  DATA_W  core received byte; valid while core_rx_ready_i = 1.
- core_read_en_o  out  1  one-cycle pulse; consumes the core byte (wired to the core's data_read_en_i).
- pop_i  in  1  CPU read of the RXDATA register; advances the FIFO.
- data_o  out  DATA_W  head-of-FIFO byte.
- valid_o  out  1  FIFO non-empty.
- level_o  out  ADDR_W+1  number of stored bytes, 0..DEPTH.
- thresh_i  in  ADDR_W+1  interrupt threshold; 0 disables.
- thresh_irq_o  out  1  level_o >= thresh_i and thresh_i != 0.
- overflow_o  out  1  sticky: core held a byte while the FIFO was full.
- overflow_clr_i  in  1  clears overflow_o.

Behaviour:
- Reset (rst_i or rst_soft_i), evaluated on the clk_i edge, sets:
  - pointers = 0, level_o = 0, valid_o = 0, data_o = 0;
  - core_read_en_o = 0, thresh_irq_o = 0, overflow_o = 0;
  - FSM = IDLE.
- Reset mid-transfer discards FIFO contents. The core's held byte is untouched and is drained after reset.
- Drain FSM:
  - IDLE: if core_rx_ready_i and level_o < DEPTH (pre-pop level), write core_rx_data_i at wr_ptr, assert core_read_en_o for exactly this cycle, and go to SETTLE.
  - SETTLE: one cycle, core_read_en_o = 0, no push. Covers the core's registered clearing of rx_ready. Then return to IDLE.
  - Maximum drain rate is 1 byte per 2 cycles, far above the UART line rate.
- Full stall: in IDLE with core_rx_ready_i = 1 and level_o == DEPTH:
  - no push, no read pulse;
  - overflow_o set to 1 the next cycle;
  - the byte stays in the core, and the core's own overrun behaviour applies to any later byte.
- FWFT output:
  - data_o is registered and always equals mem[rd_ptr] while valid_o = 1.
  - A byte pushed into an empty FIFO at edge N gives valid_o = 1 and the new data_o after edge N+1 (one-cycle latency).
  - data_o holds its last value when empty.
- pop_i:
  - with valid_o = 1: rd_ptr++ and the next entry appears the following cycle;
  - with valid_o = 0: ignored, no underflow and no state change.
- Simultaneous push and pop: level_o unchanged and both pointers advance. A push into a FIFO with level 1 that is popping the same cycle must show the pushed byte next cycle (bypass into the data_o register).
- Full and pop in the same cycle: push decision uses the pre-pop level, so no push that cycle; the push occurs the next IDLE cycle.
- Pointers are ADDR_W bits and wrap modulo DEPTH. level_o is tracked as a separate ADDR_W+1 counter (+1 push, -1 pop, unchanged if both).
- thresh_irq_o is registered from the updated level (one cycle after the level changes) and is level-sensitive.
- overflow_o:
  - set has priority over overflow_clr_i in the same cycle;
  - a clear with no set condition gives 0 next cycle.
- en_i = 0 freezes the FSM, pointers, level and flags; core_read_en_o is forced to 0.

Decomposition:
- Shared package/header:
  - FSM state encodings IDLE = 1'b0, SETTLE = 1'b1;
  - DEPTH = 2**ADDR_W;
  - RXDATA register address constant, reused to decode pop_i in the top level.
- One natural sub-module: iob_uart_fifo_ram, a DEPTH×DATA_W register-array storage with a registered read port (synchronous reset of the pointers only, not of the storage).
- Top level holds the FSM, pointers, level, flags and bypass logic.

Test Plan:
1. Reset then idle: hold rst_i for 2 cycles -> level_o = 0, valid_o = 0, data_o = 0x00, core_read_en_o = 0, overflow_o = 0.
2. Single byte: core_rx_ready_i = 1 with data 0xA5 -> core_read_en_o is a 1-cycle pulse; one cycle later valid_o = 1, data_o = 0xA5, level_o = 1; pop_i -> valid_o = 0, level_o = 0.
3. Fill and wrap: push 0x00..0x0F -> level_o = 16; pop 4, push 0x10..0x13 -> pops return 0x04..0x13 in order, covering pointer wrap.
4. Full stall and overflow: with 16 bytes held, assert core_rx_ready_i (data 0x55) -> no core_read_en_o, overflow_o = 1; one pop -> 0x55 accepted within 2 cycles; overflow_clr_i -> overflow_o = 0.
5. Threshold IRQ: thresh_i = 3, push 3 bytes -> thresh_irq_o = 1 one cycle after level_o = 3; pop 1 -> 0; thresh_i = 0 -> stays 0 at any level.
6. Concurrency and soft reset: level 1, push 0x77 and pop in the same cycle -> level_o = 1, data_o = 0x77 next cycle; rst_soft_i with 5 bytes stored -> level_o = 0 next cycle, held core byte drained afterwards.

Source files
------------

// File: rtl/iob_uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive FIFO slice.
// Drain FSM encoding, depth helper and the CPU register address that maps to a FIFO pop.
package iob_uart_rx_fifo_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } rx_state_t;

   localparam logic [3:0] RXDATA_ADDR = 4'h1;

   function automatic int depth_f(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/iob_uart_rx_fifo_if.sv
// Core-side and CPU-side signals of the receive FIFO; names are from the FIFO's point of view.
// slave = the FIFO itself, master = the core/CPU environment driving it.
interface iob_uart_rx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              core_rx_ready_i;
   logic [DATA_W-1:0] core_rx_data_i;
   logic              core_read_en_o;
   logic              pop_i;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic [ADDR_W:0]   level_o;
   logic [ADDR_W:0]   thresh_i;
   logic              thresh_irq_o;
   logic              overflow_o;
   logic              overflow_clr_i;

   modport slave (
      input  core_rx_ready_i, core_rx_data_i, pop_i, thresh_i, overflow_clr_i,
      output core_read_en_o, data_o, valid_o, level_o, thresh_irq_o, overflow_o
   );

   modport master (
      output core_rx_ready_i, core_rx_data_i, pop_i, thresh_i, overflow_clr_i,
      input  core_read_en_o, data_o, valid_o, level_o, thresh_irq_o, overflow_o
   );
endinterface

// File: rtl/iob_uart_fifo_ram.sv
// DEPTH x DATA_W register-array storage, one write port and one registered read port.
// Read data lands one cycle after re_i; a same-edge write to the read address returns the old word.
module iob_uart_fifo_ram
   import iob_uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   localparam int DEPTH = depth_f(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Only the output register is cleared; the array keeps stale contents.
   always_ff @(posedge clk_i) begin
      if (rst_i)     rdata_o <= '0;
      else if (re_i) rdata_o <= mem[raddr_i];
   end
endmodule

// File: rtl/iob_uart_rx_fifo.sv
// Drains the UART core's holding register into a FWFT FIFO with level, threshold IRQ and overflow flag.
// Core byte taken at most every 2 cycles; a full FIFO leaves the byte in the core and sets overflow.
module iob_uart_rx_fifo
   import iob_uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rst_soft_i,
   input  logic                 en_i,
   iob_uart_rx_fifo_if.slave    bus
);
   localparam int DEPTH = depth_f(ADDR_W);
   localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic              rst;
   rx_state_t         state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, rd_addr;
   logic [ADDR_W:0]   level_q, level_left;
   logic              valid_q, irq_q, ovf_q, byp_sel_q;
   logic [DATA_W-1:0] byp_dat_q, ram_rdata;
   logic              push, stall, pop, bypass, valid_d, rd_en;

   assign rst = rst_i | rst_soft_i;

   always_ff @(posedge clk_i) begin
      if (rst)       state_q <= IDLE;
      else if (en_i) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (push) state_d = SETTLE;
      end else begin
         state_d = IDLE;
      end
   end

   // No read pulse during reset, so the core keeps its byte for after reset.
   always_comb begin
      push  = 1'b0;
      stall = 1'b0;
      if (!rst && en_i && state_q == IDLE && bus.core_rx_ready_i) begin
         if (level_q == LVL_FULL) stall = 1'b1;
         else                     push  = 1'b1;
      end
   end

   assign bus.core_read_en_o = push;

   assign pop        = en_i & bus.pop_i & valid_q;
   assign level_left = level_q - {{ADDR_W{1'b0}}, pop};
   assign rd_addr    = rd_ptr_q + {{(ADDR_W-1){1'b0}}, pop};
   // Popping the last entry while pushing: the new byte would be read before it is written.
   assign bypass     = push & pop & (level_q == LVL_ONE);
   assign valid_d    = bypass | (level_left != '0);
   assign rd_en      = en_i & valid_d & ~bypass;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         valid_q   <= 1'b0;
         byp_sel_q <= 1'b0;
         irq_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (en_i) begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         rd_ptr_q <= rd_addr;
         level_q  <= level_left + {{ADDR_W{1'b0}}, push};
         valid_q  <= valid_d;
         if (valid_d) byp_sel_q <= bypass;
         irq_q    <= (bus.thresh_i != '0) && (level_q >= bus.thresh_i);
         if (stall)                   ovf_q <= 1'b1;
         else if (bus.overflow_clr_i) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (bypass) byp_dat_q <= bus.core_rx_data_i;
   end

   iob_uart_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.core_rx_data_i),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   assign bus.data_o       = byp_sel_q ? byp_dat_q : ram_rdata;
   assign bus.valid_o      = valid_q;
   assign bus.level_o      = level_q;
   assign bus.thresh_irq_o = irq_q;
   assign bus.overflow_o   = ovf_q;
endmodule

// File: tb/tb_iob_uart_rx_fifo.sv
// Bench for iob_uart_rx_fifo: vector table, directed corner sequences, then random traffic
// against a queue-based reference of the receive FIFO behaviour.
module tb_iob_uart_rx_fifo;
   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst, rst_soft, en;
   int   total = 0;
   int   bad   = 0;

   iob_uart_rx_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   iob_uart_rx_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rst_soft_i (rst_soft),
      .en_i       (en),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       rdy;
      logic [7:0] dat;
      logic       pop;
      logic [4:0] thr;
      logic       clr;
      logic       re;
      logic [4:0] lvl;
      logic       vld;
      logic [7:0] d;
      logic       irq;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic e, input logic r, input logic [7:0] dt, input logic p,
                               input logic [4:0] t, input logic c, input logic xre,
                               input logic [4:0] xl, input logic xv, input logic [7:0] xd,
                               input logic xi, input logic xo);
      vec_t v;
      v.en = e; v.rdy = r; v.dat = dt; v.pop = p; v.thr = t; v.clr = c;
      v.re = xre; v.lvl = xl; v.vld = xv; v.d = xd; v.irq = xi; v.ovf = xo;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.core_rx_ready_i = 1'b0;
      bus.core_rx_data_i  = '0;
      bus.pop_i           = 1'b0;
      bus.thresh_i        = '0;
      bus.overflow_clr_i  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; rst_soft = 1'b0; en = 1'b1;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_level", bus.level_o, 0);
      check("rst_valid", bus.valid_o, 0);
      check("rst_data", bus.data_o, 8'h00);
      check("rst_re", bus.core_read_en_o, 0);
      check("rst_ovf", bus.overflow_o, 0);
      check("rst_irq", bus.thresh_irq_o, 0);
   endtask

   // Presents one core byte until it is consumed, then lets the settle cycle pass.
   task automatic push_byte(input logic [7:0] b);
      int n = 0;
      bus.core_rx_ready_i = 1'b1;
      bus.core_rx_data_i  = b;
      #1;
      while (bus.core_read_en_o !== 1'b1 && n < 8) begin
         @(negedge clk); #1; n++;
      end
      check("push_ack", bus.core_read_en_o, 1);
      @(negedge clk);
      bus.core_rx_ready_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop_check(input logic [7:0] exp, input string tag);
      check({tag, "_vld"}, bus.valid_o, 1);
      check({tag, "_dat"}, bus.data_o, exp);
      bus.pop_i = 1'b1;
      @(negedge clk);
      bus.pop_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] q[$];
      logic       vm, irqm, ovfm, settle, core_has, exp_re, pe, st;
      logic [7:0] core_byte;
      logic [4:0] thr;
      int         sb, pop_pct;

      // ---------------- table: single byte, threshold, enable ----------------
      vecs.push_back(mk(1,1,8'hA5,0,3,0, 1, 1,0,8'h00,0,0));
      vecs.push_back(mk(1,0,8'h00,0,3,0, 0, 1,1,8'hA5,0,0));
      vecs.push_back(mk(1,0,8'h00,1,3,0, 0, 0,0,8'hA5,0,0));
      vecs.push_back(mk(1,0,8'h00,1,3,0, 0, 0,0,8'hA5,0,0));
      vecs.push_back(mk(1,1,8'h11,0,3,0, 1, 1,0,8'hA5,0,0));
      vecs.push_back(mk(1,1,8'h22,0,3,0, 0, 1,1,8'h11,0,0));
      vecs.push_back(mk(1,1,8'h22,0,3,0, 1, 2,1,8'h11,0,0));
      vecs.push_back(mk(1,1,8'h33,0,3,0, 0, 2,1,8'h11,0,0));
      vecs.push_back(mk(1,1,8'h33,0,3,0, 1, 3,1,8'h11,0,0));
      vecs.push_back(mk(1,0,8'h00,0,3,0, 0, 3,1,8'h11,1,0));
      vecs.push_back(mk(1,0,8'h00,1,3,0, 0, 2,1,8'h22,1,0));
      vecs.push_back(mk(1,0,8'h00,0,3,0, 0, 2,1,8'h22,0,0));
      vecs.push_back(mk(1,0,8'h00,0,1,0, 0, 2,1,8'h22,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 0, 2,1,8'h22,0,0));
      vecs.push_back(mk(1,0,8'h00,0,0,1, 0, 2,1,8'h22,0,0));
      vecs.push_back(mk(0,1,8'h44,1,5,0, 0, 2,1,8'h22,0,0));
      vecs.push_back(mk(1,0,8'h00,1,0,0, 0, 1,1,8'h33,0,0));

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         en                  = vecs[i].en;
         bus.core_rx_ready_i = vecs[i].rdy;
         bus.core_rx_data_i  = vecs[i].dat;
         bus.pop_i           = vecs[i].pop;
         bus.thresh_i        = vecs[i].thr;
         bus.overflow_clr_i  = vecs[i].clr;
         #1;
         check($sformatf("v%0d_re", i), bus.core_read_en_o, vecs[i].re);
         @(negedge clk);
         check($sformatf("v%0d_lvl", i), bus.level_o, vecs[i].lvl);
         check($sformatf("v%0d_vld", i), bus.valid_o, vecs[i].vld);
         check($sformatf("v%0d_dat", i), bus.data_o, vecs[i].d);
         check($sformatf("v%0d_irq", i), bus.thresh_irq_o, vecs[i].irq);
         check($sformatf("v%0d_ovf", i), bus.overflow_o, vecs[i].ovf);
      end
      en = 1'b1;
      idle_inputs();

      // ---------------- fill, drain and pointer wrap ----------------
      do_reset();
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      check("fill_level", bus.level_o, 16);
      for (int i = 0; i < 4; i++) pop_check(8'(i), "wrap_pop_a");
      for (int i = 16; i < 20; i++) push_byte(8'(i));
      check("wrap_level", bus.level_o, 16);
      for (int i = 4; i < 20; i++) pop_check(8'(i), "wrap_pop_b");
      check("wrap_empty_lvl", bus.level_o, 0);
      check("wrap_empty_vld", bus.valid_o, 0);

      // ---------------- full stall and overflow ----------------
      do_reset();
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      bus.core_rx_ready_i = 1'b1;
      bus.core_rx_data_i  = 8'h55;
      #1;
      check("stall_no_re", bus.core_read_en_o, 0);
      @(negedge clk);
      check("stall_ovf", bus.overflow_o, 1);
      check("stall_level", bus.level_o, 16);
      bus.pop_i = 1'b1;
      #1;
      check("full_pop_no_push", bus.core_read_en_o, 0);
      @(negedge clk);
      bus.pop_i = 1'b0;
      check("full_pop_level", bus.level_o, 15);
      check("full_pop_dat", bus.data_o, 8'h01);
      #1;
      check("drain_after_pop", bus.core_read_en_o, 1);
      @(negedge clk);
      bus.core_rx_ready_i = 1'b0;
      check("refill_level", bus.level_o, 16);
      check("ovf_sticky", bus.overflow_o, 1);
      bus.overflow_clr_i = 1'b1;
      @(negedge clk);
      bus.overflow_clr_i = 1'b0;
      check("ovf_cleared", bus.overflow_o, 0);
      for (int i = 1; i < 16; i++) pop_check(8'(i), "ovf_pop");
      pop_check(8'h55, "ovf_pop_last");

      // ---------------- concurrent push/pop and soft reset ----------------
      do_reset();
      push_byte(8'h66);
      check("conc_pre_dat", bus.data_o, 8'h66);
      bus.core_rx_ready_i = 1'b1;
      bus.core_rx_data_i  = 8'h77;
      bus.pop_i           = 1'b1;
      #1;
      check("conc_re", bus.core_read_en_o, 1);
      @(negedge clk);
      bus.core_rx_ready_i = 1'b0;
      bus.pop_i           = 1'b0;
      check("conc_level", bus.level_o, 1);
      check("conc_vld", bus.valid_o, 1);
      check("conc_dat", bus.data_o, 8'h77);
      for (int i = 0; i < 4; i++) push_byte(8'h80 + 8'(i));
      check("sr_pre_level", bus.level_o, 5);
      rst_soft            = 1'b1;
      bus.core_rx_ready_i = 1'b1;
      bus.core_rx_data_i  = 8'h99;
      #1;
      check("sr_no_re", bus.core_read_en_o, 0);
      @(negedge clk);
      rst_soft = 1'b0;
      check("sr_level", bus.level_o, 0);
      check("sr_vld", bus.valid_o, 0);
      check("sr_dat", bus.data_o, 8'h00);
      #1;
      check("sr_drain_re", bus.core_read_en_o, 1);
      @(negedge clk);
      bus.core_rx_ready_i = 1'b0;
      check("sr_drain_lvl", bus.level_o, 1);
      @(negedge clk);
      check("sr_drain_vld", bus.valid_o, 1);
      check("sr_drain_dat", bus.data_o, 8'h99);

      // ---------------- random traffic against queue reference ----------------
      do_reset();
      q.delete();
      vm = 0; irqm = 0; ovfm = 0; settle = 0; core_has = 0; core_byte = '0; thr = '0;
      pop_pct = 30;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         check("rnd_level", bus.level_o, q.size());
         check("rnd_vld", bus.valid_o, vm);
         if (vm) check("rnd_dat", bus.data_o, q[0]);
         check("rnd_irq", bus.thresh_irq_o, irqm);
         check("rnd_ovf", bus.overflow_o, ovfm);

         if (cyc % 500 == 0) pop_pct = (cyc / 500) % 3 == 0 ? 10 : ((cyc / 500) % 3 == 1 ? 35 : 60);
         en = ($urandom_range(0, 15) != 0);
         if (!core_has && $urandom_range(0, 2) == 0) begin
            core_has  = 1'b1;
            core_byte = 8'($urandom);
         end
         if ($urandom_range(0, 49) == 0) thr = 5'($urandom_range(0, 16));
         bus.core_rx_ready_i = core_has;
         bus.core_rx_data_i  = core_has ? core_byte : 8'($urandom);
         bus.pop_i           = ($urandom_range(0, 99) < pop_pct);
         bus.thresh_i        = thr;
         bus.overflow_clr_i  = ($urandom_range(0, 19) == 0);
         #1;
         sb     = q.size();
         exp_re = en && core_has && !settle && sb < 16;
         check("rnd_re", bus.core_read_en_o, exp_re);

         pe = en && bus.pop_i && vm;
         st = en && core_has && !settle && sb == 16;
         if (en) begin
            if (pe) void'(q.pop_front());
            if (exp_re) begin
               q.push_back(core_byte);
               core_has = 1'b0;
            end
            irqm   = (thr != 0) && (sb >= int'(thr));
            ovfm   = st ? 1'b1 : (bus.overflow_clr_i ? 1'b0 : ovfm);
            vm     = (q.size() > 0) && (sb > 0);
            settle = exp_re;
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
